// File: rtl/mem_arbiter.sv
// mem_arbiter: N-client round-robin arbiter onto one registered line memory port.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module mem_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 28,
  parameter int LINE_W  = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORTS-1:0]        cl_read,
  input  logic [N_PORTS-1:0]        cl_write,
  input  logic [N_PORTS*ADDR_W-1:0] cl_addr,
  input  logic [N_PORTS*LINE_W-1:0] cl_wdata,
  output logic [LINE_W-1:0]         cl_rdata,
  output logic [N_PORTS-1:0]        cl_ready,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [LINE_W-1:0]         mem_wdata,
  input  logic [LINE_W-1:0]         mem_rdata,
  input  logic                      mem_ready
);

  localparam int IDX_W = $clog2(N_PORTS);
  localparam logic [IDX_W:0] NP = (IDX_W+1)'(N_PORTS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PORTS-1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, grant_q, win;
  logic [N_PORTS-1:0]  req;
  logic                found;
  logic [IDX_W:0]      cand;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LINE_W-1:0]   sel_wdata;
  logic                sel_wr;
  logic [LINE_W-1:0]   rdata_q;

  // first requester at or after the pointer, wrapping modulo N_PORTS
  always_comb begin
    req   = cl_read | cl_write;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= NP) cand = cand - NP;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (win == IDX_W'(i)) begin
        sel_addr  = cl_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = cl_wdata[i*LINE_W +: LINE_W];
        sel_wr    = cl_write[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = BUSY;
      BUSY:    if (mem_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
    end else if (state_q == IDLE) begin
      if (found) begin
        grant_q   <= win;
        mem_read  <= ~sel_wr;
        mem_write <= sel_wr;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
    end else if (state_q == BUSY) begin
      if (mem_ready) begin
        if (mem_read) rdata_q <= mem_rdata;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_q <= '0;
    else if (state_q == IDLE && found)
      ptr_q <= (win == LAST) ? '0 : win + 1'b1;
  end
`endif

  always_comb begin
    cl_ready = '0;
    for (int i = 0; i < N_PORTS; i++)
      cl_ready[i] = (state_q == DONE) && (grant_q == IDX_W'(i));
  end

  assign cl_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random clients and memory against a transaction-level model.
// Build with ARB_FIXED_PRIO_EN to check fixed-priority mode.
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 28;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  cl_read, cl_write, cl_ready;
  logic [N*AW-1:0] cl_addr;
  logic [N*LW-1:0] cl_wdata;
  logic [LW-1:0] cl_rdata, mem_wdata, mem_rdata;
  logic          mem_read, mem_write, mem_ready;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.N_PORTS(N), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cl_read(cl_read), .cl_write(cl_write),
    .cl_addr(cl_addr), .cl_wdata(cl_wdata),
    .cl_rdata(cl_rdata), .cl_ready(cl_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // model: phase 0 = arbiter free, 1 = transaction open, 2 = ack cycle
  int            m_ptr, m_ph, nph, w, op;
  logic          exp_rd, exp_wr;
  logic [AW-1:0] exp_addr;
  logic [LW-1:0] exp_wd, m_rdata, rdata_nxt;
  logic [N-1:0]  req, onehot;
  bit            did_rst;

  initial begin
    cl_read = '0; cl_write = '0; cl_addr = '0; cl_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    m_ptr = 0; m_ph = 0; m_rdata = '0; did_rst = 1'b0;
    w = 0; exp_rd = 0; exp_wr = 0; exp_addr = '0; exp_wd = '0;
    rdata_nxt = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cl_ready", cl_ready, 0);
    check("rst_cl_rdata", cl_rdata, 0);
    tick(); tick();
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      req = cl_read | cl_write;
      nph = m_ph;
      if (m_ph == 0) begin
        if (req != '0) begin
          w = rr_pick(req, m_ptr);
          exp_wr = cl_write[w];
          exp_rd = !cl_write[w];
          exp_addr = cl_addr[w*AW +: AW];
          exp_wd = cl_wdata[w*LW +: LW];
`ifndef ARB_FIXED_PRIO_EN
          m_ptr = (w + 1) % N;
`endif
          nph = 1;
        end
      end else if (m_ph == 1) begin
        if (mem_ready) begin
          nph = 2;
          rdata_nxt = exp_rd ? mem_rdata : m_rdata;
        end
      end else begin
        nph = 0;
      end

      tick();

      if (nph == 1) begin
        check("busy_mem_read", mem_read, exp_rd);
        check("busy_mem_write", mem_write, exp_wr);
        check("busy_mem_addr", mem_addr, exp_addr);
        check("busy_mem_wdata", mem_wdata, exp_wd);
        check("busy_cl_ready", cl_ready, 0);
      end else if (nph == 2) begin
        m_rdata = rdata_nxt;
        onehot = N'(1) << w;
        check("done_cl_ready", cl_ready, onehot);
        check("done_mem_read", mem_read, 0);
        check("done_mem_write", mem_write, 0);
        check("done_cl_rdata", cl_rdata, m_rdata);
        cl_read[w] = 1'b0;
        cl_write[w] = 1'b0;
      end else begin
        check("idle_cl_ready", cl_ready, 0);
        check("idle_strobes", {mem_read, mem_write}, 0);
        check("idle_cl_rdata", cl_rdata, m_rdata);
      end
      m_ph = nph;

      for (int i = 0; i < N; i++) begin
        if (!(cl_read[i] | cl_write[i]) && $urandom_range(2) == 0) begin
          op = $urandom_range(2);
          cl_read[i] = (op != 1);
          cl_write[i] = (op != 0);
          cl_addr[i*AW +: AW] = AW'($urandom);
          cl_wdata[i*LW +: LW] = rnd_line();
        end
      end
      if (m_ph == 1) mem_ready = ($urandom_range(2) == 0);
      else mem_ready = 1'($urandom_range(1));
      mem_rdata = rnd_line();

      if (cyc > 2000 && !did_rst && m_ph == 1) begin
        rst_n = 1'b0;
        #1;
        check("arst_mem_read", mem_read, 0);
        check("arst_mem_write", mem_write, 0);
        check("arst_cl_ready", cl_ready, 0);
        check("arst_cl_rdata", cl_rdata, 0);
        tick(); tick();
        check("arst_hold_strobes", {mem_read, mem_write}, 0);
        check("arst_hold_ready", cl_ready, 0);
        rst_n = 1'b1;
        m_ptr = 0;
        m_ph = 0;
        m_rdata = '0;
        did_rst = 1'b1;
      end
    end

    check("reset_test_reached", did_rst, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
